sort4_stream_ctrl: RTL and testbench
====================================

# sort4_stream_ctrl

Sequencing controller that feeds a 4-input, 4-bit `sort_4` sorting network from a serial valid/ready input stream and returns the sorted values as a serial valid/ready output stream. It collects up to four nibbles per group, applies them in parallel to one `sort_4` instance, registers the result, then drains it one value per handshake. It sits between a serial nibble producer (switch/UART front end) and a serial consumer (display/LED driver) in the lab datapath.

## Interface
- No parameters; width is 4 bits and group size is 4, fixed by `sort_4`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a nibble on `in_data`.
- `in_data`  in  4  input nibble.
- `in_last`  in  1  qualifies `in_valid`; this nibble ends the group early.
- `in_ready`  out  1  controller accepts a nibble this cycle.
- `out_valid`  out  1  `out_data` holds a sorted value.
- `out_data`  out  4  sorted value.
- `out_last`  out  1  final value of the group.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `busy`  out  1  high in SORT and DRAIN.

## Operation
- One `sort_4` instance, ports (A,B,C,D) -> (E,F,G,H), with E<=F<=G<=H unsigned.
- Input handshake: the edge where `in_valid & in_ready` holds. Output handshake: the edge where `out_valid & out_ready` holds.
- FSM states: LOAD, SORT, DRAIN. Reset state is LOAD.
- LOAD:
  - `in_ready`=1.
  - Each input handshake writes `in_data` to slot[cnt] (slot0->A … slot3->D) and increments `cnt`, a 3-bit count of values received, 0..4.
  - Go to SORT on the handshake that makes `cnt`=4, or on any handshake with `in_last`=1.
  - `in_last` on the 4th nibble is legal and is the same as a full group.
- Padding: on the SORT transition, every slot at index >= `cnt` is loaded with the pad value: 4'hF ascending, 4'h0 descending. Slots from earlier groups never leak through.
- SORT:
  - Lasts exactly one cycle; `in_ready`=0.
  - Registers E,F,G,H into `obuf[0..3]`, sets `idx`=0, and goes to DRAIN.
- DRAIN:
  - `out_valid`=1; `out_data`=`obuf[idx]`; `out_last`=(`idx`==`cnt`-1).
  - Each output handshake increments `idx`.
  - The handshake with `out_last`=1 clears `cnt` and goes to LOAD.
  - Only `cnt` values are emitted; pads are never output.
- While `out_ready`=0, `out_data`/`out_last` hold steady.
- `in_valid` outside LOAD is ignored.
- Ties are emitted as duplicates. Data equal to the pad value is emitted normally.

## Timing
- Values in the first cycle after `rst` is released: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `cnt`=0, `idx`=0.
- While `rst`=1, `in_ready`=0 and `out_valid`=0.
- Reset mid-group or mid-drain discards all collected and buffered data. No further output is emitted from that group.
- Latency: `out_valid` is first high in the 2nd cycle after the final input handshake edge (one SORT cycle in between).
- Group throughput: with `out_ready` held at 1 and `in_valid` asserted back-to-back, a full group repeats every 4 (load) + 1 (sort) + 4 (drain) = 9 cycles.
- `in_ready` and `out_valid` are never both high. `in_ready` rises in the cycle after the `out_last` handshake.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_*` or `out_ready` to any output.

## Configuration
- Macro: `SORT4_CTRL_DESC_EN`.
- Undefined (ascending):
  - Pad value is 4'hF.
  - DRAIN emits `obuf[0]` upward (E first).
- Defined (descending):
  - Pad value is 4'h0.
  - DRAIN emits `obuf[3]` downward (H first). `out_last` is on the `cnt`-th value emitted.
- The `sort_4` instance and all handshake timing are identical in both builds.

## Test plan
- Full group: input 9,3,C,1 with `out_ready`=1 -> output 1,3,9,C; `out_last` only on C; `out_valid` first high 2 cycles after the 4th input edge. In the DESC build -> C,9,3,1.
- Short group: input 7, then 2 with `in_last`=1 -> output 2,7 with `out_last` on 7; no F is emitted. In the DESC build -> 7,2 with no 0 emitted.
- Backpressure: full group 5,5,0,F with `out_ready` toggling 1,0,0,1,… -> output 0,5,5,F; `out_data` holds while stalled; `in_ready`=0 throughout DRAIN.
- Stale slots: group A,B,C,D, then a group of only 4 with `in_last`=1 -> second group output is exactly one value, 4, with `out_last`=1.
- Reset mid-operation:
  - `rst` asserted for one cycle after 2 inputs -> the next full group 8,6,4,2 outputs 2,4,6,8 only.
  - `rst` asserted during DRAIN -> `out_valid`=0 in the cycle after the `rst` edge; `in_ready`=1 in the first cycle after release.
- Single element with `in_last`, and back-to-back groups with `in_valid` held at 1 -> one value out with `out_last`=1; 9-cycle group period confirmed.

Source files
------------

// File: rtl/sort4_stream_ctrl.sv
// Serial-to-parallel sequencer around a 4-input, 4-bit sort_4 network.
// Define SORT4_CTRL_DESC_EN to pad with 4'h0 and drain the largest value first.

module sort_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  output logic [3:0] e,
  output logic [3:0] f,
  output logic [3:0] g,
  output logic [3:0] h
);
  logic [3:0] lo_ab, hi_ab, lo_cd, hi_cd, mid_x, mid_y;

  // Five-comparator network: sort pairs, take the extremes, then order the two middles.
  assign lo_ab = (a <= b) ? a : b;
  assign hi_ab = (a <= b) ? b : a;
  assign lo_cd = (c <= d) ? c : d;
  assign hi_cd = (c <= d) ? d : c;
  assign e     = (lo_ab <= lo_cd) ? lo_ab : lo_cd;
  assign mid_x = (lo_ab <= lo_cd) ? lo_cd : lo_ab;
  assign h     = (hi_ab <= hi_cd) ? hi_cd : hi_ab;
  assign mid_y = (hi_ab <= hi_cd) ? hi_ab : hi_cd;
  assign f     = (mid_x <= mid_y) ? mid_x : mid_y;
  assign g     = (mid_x <= mid_y) ? mid_y : mid_x;
endmodule

module sort4_stream_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

`ifdef SORT4_CTRL_DESC_EN
  localparam logic [3:0] PAD = 4'h0;
`else
  localparam logic [3:0] PAD = 4'hF;
`endif

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] slot_q [4];
  logic [3:0] slot_d [4];
  logic [3:0] obuf_q [4];
  logic [3:0] obuf_d [4];
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       busy_q, busy_d;
  logic [3:0] srt_e, srt_f, srt_g, srt_h;

  sort_4 u_sort (
    .a(slot_q[0]),
    .b(slot_q[1]),
    .c(slot_q[2]),
    .d(slot_q[3]),
    .e(srt_e),
    .f(srt_f),
    .g(srt_g),
    .h(srt_h)
  );

  function automatic logic [1:0] drain_sel(input logic [1:0] i);
`ifdef SORT4_CTRL_DESC_EN
    return ~i;
`else
    return i;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    obuf_d  = obuf_q;

    case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          slot_d[cnt_q[1:0]] = in_data;
          cnt_d = cnt_q + 3'd1;
          if ((cnt_d == 3'd4) || in_last) begin
            state_d = SORT;
            // Pads sort to the far end, so leftovers from older groups can never surface.
            for (int i = 0; i < 4; i++) begin
              if (i >= int'(cnt_d)) slot_d[i] = PAD;
            end
          end
        end
      end
      SORT: begin
        obuf_d[0] = srt_e;
        obuf_d[1] = srt_f;
        obuf_d[2] = srt_g;
        obuf_d[3] = srt_h;
        idx_d     = 2'd0;
        state_d   = DRAIN;
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            cnt_d   = 3'd0;
            idx_d   = 2'd0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Outputs are precomputed from next state so they leave the block as flops.
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    busy_d      = (state_d != LOAD);
    out_data_d  = out_valid_d ? obuf_d[drain_sel(idx_d)] : 4'h0;
    out_last_d  = out_valid_d && ({1'b0, idx_d} == (cnt_d - 3'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= 3'd0;
      idx_q       <= 2'd0;
      slot_q      <= '{default: 4'h0};
      obuf_q      <= '{default: 4'h0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'h0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      slot_q      <= slot_d;
      obuf_q      <= obuf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Both handshake strobes are held off for every cycle that reset is asserted.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = out_valid_q & ~rst;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sort4_stream_ctrl.sv
// Scoreboard bench for sort4_stream_ctrl: directed groups push expected values, a monitor pops them.
// Honours SORT4_CTRL_DESC_EN so the same vectors cover the descending build.

module tb_sort4_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  logic bpMode   = 1'b0;
  logic [3:0] bpPat = 4'b1001;
  int   bpIdx    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  sort4_stream_ctrl dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected values are given in ascending order; the descending build drains them reversed.
  task automatic pushGroup(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                           input logic [3:0] v3, input int n);
    logic [3:0] v [4];
    int k2;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int k = 0; k < n; k++) begin
`ifdef SORT4_CTRL_DESC_EN
      k2 = n - 1 - k;
`else
      k2 = k;
`endif
      sb.push_back('{data: v[k2], last: (k == n - 1)});
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic last, output int hsCycle);
    logic hs;
    hs = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
    end
    checkOutput("in_handshake", {31'd0, hs}, 32'd1);
    hsCycle = cycle;
    in_last = 1'b0;
  endtask

  task automatic idleInput();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    checkOutput("drain_done", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Consumer-side ready: always 1, or the repeating 1,0,0,1 stall pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bpMode) begin
        out_ready = bpPat[3 - bpIdx];
        bpIdx = (bpIdx + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks stall stability.
  initial begin
    logic       prevStall;
    logic [4:0] prevVal;
    exp_t       e;
    prevStall = 1'b0;
    prevVal   = 5'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (out_valid) checkOutput("in_ready_while_out_valid", {31'd0, in_ready}, 32'd0);
        if (prevStall && out_valid) checkOutput("hold_while_stalled", {27'd0, out_last, out_data}, {27'd0, prevVal});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_output: got data %0h last %0b expected nothing", out_data, out_last);
          end else begin
            e = sb.pop_front();
            checkOutput("out_data", {28'd0, out_data}, {28'd0, e.data});
            checkOutput("out_last", {31'd0, out_last}, {31'd0, e.last});
          end
        end
        prevStall = out_valid && !out_ready;
        prevVal   = {out_last, out_data};
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, c1, hsDummy;
    rst = 1'b1;
    idleInput();
    in_data = 4'h0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("post_rst_out_data", {28'd0, out_data}, 32'd0);
    checkOutput("post_rst_out_last", {31'd0, out_last}, 32'd0);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] full group 9,3,C,1");
    pushGroup(4'h1, 4'h3, 4'h9, 4'hC, 4);
    applyStimulus(4'h9, 1'b0, hsDummy);
    applyStimulus(4'h3, 1'b0, hsDummy);
    applyStimulus(4'hC, 1'b0, hsDummy);
    applyStimulus(4'h1, 1'b0, hsDummy);
    idleInput();
    @(negedge clk);
    checkOutput("sort_cycle_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("sort_cycle_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("sort_cycle_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("latency_out_valid", {31'd0, out_valid}, 32'd1);
    waitDrain();

    $display("[TB] short group 7,2(last)");
    pushGroup(4'h2, 4'h7, 4'h0, 4'h0, 2);
    applyStimulus(4'h7, 1'b0, hsDummy);
    applyStimulus(4'h2, 1'b1, hsDummy);
    idleInput();
    waitDrain();

    $display("[TB] backpressure 5,5,0,F");
    bpMode = 1'b1;
    pushGroup(4'h0, 4'h5, 4'h5, 4'hF, 4);
    applyStimulus(4'h5, 1'b0, hsDummy);
    applyStimulus(4'h5, 1'b0, hsDummy);
    applyStimulus(4'h0, 1'b0, hsDummy);
    applyStimulus(4'hF, 1'b0, hsDummy);
    idleInput();
    waitDrain();
    bpMode = 1'b0;

    $display("[TB] stale slots A,B,C,D(last) then 4(last)");
    pushGroup(4'hA, 4'hB, 4'hC, 4'hD, 4);
    applyStimulus(4'hA, 1'b0, hsDummy);
    applyStimulus(4'hB, 1'b0, hsDummy);
    applyStimulus(4'hC, 1'b0, hsDummy);
    applyStimulus(4'hD, 1'b1, hsDummy);
    idleInput();
    waitDrain();
    pushGroup(4'h4, 4'h0, 4'h0, 4'h0, 1);
    applyStimulus(4'h4, 1'b1, hsDummy);
    idleInput();
    waitDrain();

    $display("[TB] reset after two inputs");
    applyStimulus(4'hE, 1'b0, hsDummy);
    applyStimulus(4'h1, 1'b0, hsDummy);
    idleInput();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushGroup(4'h2, 4'h4, 4'h6, 4'h8, 4);
    applyStimulus(4'h8, 1'b0, hsDummy);
    applyStimulus(4'h6, 1'b0, hsDummy);
    applyStimulus(4'h4, 1'b0, hsDummy);
    applyStimulus(4'h2, 1'b0, hsDummy);
    idleInput();
    waitDrain();

    $display("[TB] reset during drain");
    pushGroup(4'h1, 4'h3, 4'h9, 4'hC, 4);
    applyStimulus(4'h9, 1'b0, hsDummy);
    applyStimulus(4'h3, 1'b0, hsDummy);
    applyStimulus(4'hC, 1'b0, hsDummy);
    applyStimulus(4'h1, 1'b0, hsDummy);
    idleInput();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    checkOutput("drain_reached", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checkOutput("rst_drain_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_drain_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("after_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] single element then back-to-back groups");
    pushGroup(4'h6, 4'h0, 4'h0, 4'h0, 1);
    applyStimulus(4'h6, 1'b1, hsDummy);
    pushGroup(4'h1, 4'h3, 4'h9, 4'hC, 4);
    applyStimulus(4'h9, 1'b0, c0);
    applyStimulus(4'h3, 1'b0, hsDummy);
    applyStimulus(4'hC, 1'b0, hsDummy);
    applyStimulus(4'h1, 1'b0, hsDummy);
    pushGroup(4'h2, 4'h4, 4'h6, 4'h8, 4);
    applyStimulus(4'h8, 1'b0, c1);
    applyStimulus(4'h6, 1'b0, hsDummy);
    applyStimulus(4'h4, 1'b0, hsDummy);
    applyStimulus(4'h2, 1'b0, hsDummy);
    idleInput();
    checkOutput("group_period", c1 - c0, 32'd9);
    waitDrain();

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
